// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, one bit per clock with a per-bit valid strobe.
// A new word can be accepted during the last bit of the current one, giving a gapless stream.
module serializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [DATA_BUS_WIDTH-1:0] data_i,
    input  logic [MOD_WIDTH-1:0]      data_mod_i,
    input  logic                      data_val_i,
    output logic                      busy_o,
    output logic                      ser_data_o,
    output logic                      ser_data_val_o
);

    // state  | meaning
    // IDLE_S | no word in flight, outputs held at 0
    // SEND_S | emitting bits; cnt holds bits remaining including the one on the output
    typedef enum logic [1:0] {
        IDLE_S = 2'b00,
        SEND_S = 2'b01
    } state_t;

    localparam int               CNT_W    = MOD_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BUS_WIDTH);

    state_t                    state, state_nxt;
    logic [DATA_BUS_WIDTH-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic                      ser_data_nxt, ser_data_val_nxt;
    logic                      accept, do_load;
    logic [CNT_W-1:0]          len;

    assign busy_o = (state == SEND_S) && (cnt > CNT_ONE);
    assign accept = data_val_i && !busy_o;
    assign len    = (data_mod_i == '0) ? CNT_FULL : {1'b0, data_mod_i};

    always_comb begin
        state_nxt        = state;
        shift_nxt        = shift_reg;
        cnt_nxt          = cnt;
        ser_data_nxt     = 1'b0;
        ser_data_val_nxt = 1'b0;
        do_load          = 1'b0;
        case (state)
            IDLE_S: begin
                do_load = accept;
            end
            SEND_S: begin
                if (cnt > CNT_ONE) begin
                    ser_data_nxt     = shift_reg[DATA_BUS_WIDTH-1];
                    ser_data_val_nxt = 1'b1;
                    shift_nxt        = shift_reg << 1;
                    cnt_nxt          = cnt - CNT_ONE;
                end else if (accept) begin
                    do_load = 1'b1;
                end else begin
                    state_nxt = IDLE_S;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt        = state_t'('x);
                shift_nxt        = 'x;
                cnt_nxt          = 'x;
                ser_data_nxt     = 1'bx;
                ser_data_val_nxt = 1'bx;
            end
        endcase
        // The first bit goes straight to the output; the register keeps only what is left.
        if (do_load) begin
            state_nxt        = SEND_S;
            ser_data_nxt     = data_i[DATA_BUS_WIDTH-1];
            ser_data_val_nxt = 1'b1;
            shift_nxt        = {data_i[DATA_BUS_WIDTH-2:0], 1'b0};
            cnt_nxt          = len;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state          <= IDLE_S;
            shift_reg      <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
        end else begin
            state          <= state_nxt;
            shift_reg      <= shift_nxt;
            cnt            <= cnt_nxt;
            ser_data_o     <= ser_data_nxt;
            ser_data_val_o <= ser_data_val_nxt;
        end
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter that sits directly upstream of the team's deserializer and feeds its `data_i` / `data_val_i` inputs.
- Accepts one parallel word plus a bit-count modifier through a valid/busy handshake.
- Emits the word's bits one per clock, MSB (bit DATA_BUS_WIDTH-1) first, with a per-bit valid strobe.
- Supports gapless back-to-back words, so a continuous stream can be produced.

Parameters:
- DATA_BUS_WIDTH, 16: parallel word width in bits; must be at least 2.
- MOD_WIDTH, $clog2(DATA_BUS_WIDTH): width of `data_mod_i`; derived, not to be overridden.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- arst_n_i  input  1  asynchronous, active-low reset.
- data_i  input  DATA_BUS_WIDTH  parallel word to transmit.
- data_mod_i  input  MOD_WIDTH  number of bits to send, counted from the MSB; 0 means all DATA_BUS_WIDTH bits.
- data_val_i  input  1  word valid; word is accepted on a rising edge where data_val_i=1 and busy_o=0.
- busy_o  output  1  serializer cannot accept a word this cycle.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o carries a valid bit.

Behaviour:
- Reset (arst_n_i=0, asynchronous, no clock needed) drives:
  - state to IDLE_S.
  - ser_data_o=0, ser_data_val_o=0, busy_o=0.
  - internal shift register and counter to 0.
- A word in flight when reset asserts is discarded; no further bits are emitted after reset releases.
- Length: len = DATA_BUS_WIDTH when data_mod_i==0, otherwise len = data_mod_i (range 1..DATA_BUS_WIDTH-1).
- Acceptance happens at an edge where data_val_i && !busy_o.
  - data_i and len are captured into a shift register and a bit counter.
  - data_i/data_mod_i are ignored at all other times, and may change freely while busy.
- State machine:
  - IDLE_S -> SEND_S on acceptance.
  - SEND_S stays in SEND_S while bits remain.
  - At the edge ending the last bit: -> SEND_S if a new word is accepted at that same edge, else -> IDLE_S.
- Latency: for a word accepted at edge N, bits appear in the cycles following edges N .. N+len-1.
  - First bit is data_i[DATA_BUS_WIDTH-1].
  - The k-th bit is data_i[DATA_BUS_WIDTH-k].
  - Exactly len cycles have ser_data_val_o=1, contiguous.
  - Bits below position DATA_BUS_WIDTH-len are never emitted.
- ser_data_o and ser_data_val_o are registered outputs, with no combinational path from the inputs.
- ser_data_o = 0 whenever ser_data_val_o = 0.
- busy_o = (state==SEND_S) && (remaining bits > 1).
  - It is combinational from registered state only, never from data_val_i.
  - It is low during the cycle of the last bit, so a word presented then is accepted and its first bit follows with no gap.
- In IDLE_S with data_val_i=0: outputs stay 0 and state holds.
- Counter decrements once per emitted bit and never underflows; counter=1 marks the last bit.
- No default/illegal-state recovery beyond reset; unreachable state encodings drive outputs to X in simulation.

Test Plan:
- Reset mid-word:
  - Stimulus: accept 16'hA5C3 with mod=0, then assert arst_n_i low after 5 bits.
  - Required: outputs go 0 immediately, without a clock edge, and remain 0 after release with data_val_i=0.
- Full word:
  - Stimulus: after reset, pulse data_val_i one cycle with data_i=16'hA5C3, data_mod_i=0.
  - Required: 16 consecutive valid bits 1010_0101_1100_0011, then ser_data_val_o=0.
  - Required: busy_o high for the 15 cycles before the last bit.
- Partial word:
  - Stimulus: data_i=16'hF0F0, data_mod_i=4'd3.
  - Required: exactly 3 valid bits 1,1,1, then idle; busy_o high for 2 cycles.
- Back-to-back:
  - Stimulus: hold data_val_i=1, presenting 16'h8001 then 16'h0001 (mod=0), changing data on each acceptance edge.
  - Required: 32 contiguous valid cycles with no gap; bit 1 = 1, bit 16 = 1, bit 32 = 1, all other bits 0.
- Ignored input while busy:
  - Stimulus: accept 16'h00FF; mid-word, present data_val_i=1 with 16'hFFFF for 3 cycles, then drop data_val_i.
  - Required: stream is exactly 0000_0000_1111_1111 and the 16'hFFFF word is not sent.
- Minimum length, random:
  - Stimulus: mod=1 with data_i=16'h8000, then mod=1 with 16'h7FFF, back-to-back.
  - Required: bits 1 then 0 in consecutive cycles; busy_o never high.
  - Stimulus: feed 1000 random words with random mod.
  - Required: a scoreboard matches every bit and its length.
  - Required: with mod=0, the downstream deserializer reconstructs every word unchanged.
